// File: rtl/rodada_pkg.sv
// Shared definitions for the round judge: state encodings, LFSR setup
// and the default clamp window for the balance target.
package rodada_pkg;

  typedef enum logic [2:0] {
    OCIOSO = 3'd0,
    PREP   = 3'd1,
    ESPERA = 3'd2,
    JOGO   = 3'd3,
    PONTO  = 3'd4
  } estado_t;

  localparam int         LFSR_W    = 8;
  // x^8+x^6+x^5+x^4+1 on a left-shifting register: bits 7,5,4,3 feed back
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam logic [7:0] LFSR_SEED = 8'h01;

  localparam int ALVO_MIN_DEF = 32;
  localparam int ALVO_MAX_DEF = 223;

  function automatic logic [7:0] clamp_alvo(input logic [7:0] v,
                                            input logic [7:0] lo,
                                            input logic [7:0] hi);
    logic [7:0] r;
    if (v < lo) begin
      r = lo;
    end else if (v > hi) begin
      r = hi;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/rodada_lfsr.sv
// Free-running 8-bit Fibonacci LFSR used as the source of new targets.
// The seed is non-zero and the polynomial is maximal, so 0 is never reached.
module rodada_lfsr
  import rodada_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  output logic [LFSR_W-1:0] q
);

  // shift register with xor feedback from the tap mask
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= LFSR_SEED;
    end else begin
      q <= {q[LFSR_W-2:0], ^(q & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/rodada_juiz.sv
// Round judge: answers the controller's handshake with prep_done, draws a
// target, times the balance attempt and reports hit/miss with a score.
module rodada_juiz
  import rodada_pkg::*;
#(
  parameter int PREP_CYCLES    = 50_000_000,
  parameter int HOLD_CYCLES    = 100_000_000,
  parameter int TIMEOUT_CYCLES = 500_000_000,
  parameter int TOL            = 16,
  parameter int ALVO_MIN       = ALVO_MIN_DEF,
  parameter int ALVO_MAX       = ALVO_MAX_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       reset_nivel,
  input  logic       gerar_nova_jogada,
  input  logic       conta_nivel,
  input  logic [1:0] nivel,
  input  logic [7:0] angulo,
  output logic       prep_done,
  output logic       ponto_evento,
  output logic       acerto,
  output logic [7:0] alvo,
  output logic [7:0] pontos,
  output logic [2:0] db_estado
);

  localparam int PREP_W = (PREP_CYCLES > 1) ? $clog2(PREP_CYCLES) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [PREP_W-1:0] PREP_LAST = PREP_W'(PREP_CYCLES - 1);
  localparam logic [PREP_W-1:0] PREP_ONE  = PREP_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_ONE    = TO_W'(1);

  estado_t           estado_r, estado_s;
  logic [PREP_W-1:0] prep_cnt_r;
  logic [HOLD_W-1:0] hold_cnt_r;
  logic [TO_W-1:0]   to_cnt_r;
  logic [7:0]        tol_r;
  logic [7:0]        alvo_r;
  logic [7:0]        pontos_r;
  logic              acerto_r;
  logic [7:0]        lfsr_q;
  logic [8:0]        diff_s;
  logic [8:0]        mag_s;
  logic              dentro_s;
  logic              hit_s;
  logic              miss_s;

  rodada_lfsr u_lfsr (
    .clock (clock),
    .reset (reset),
    .q     (lfsr_q)
  );

  // 9-bit difference keeps the sign so the magnitude is exact over 0..255
  assign diff_s   = {1'b0, angulo} - {1'b0, alvo_r};
  assign mag_s    = diff_s[8] ? (9'd0 - diff_s) : diff_s;
  assign dentro_s = (mag_s <= {1'b0, tol_r});
  assign hit_s    = (estado_r == JOGO) && conta_nivel && dentro_s && (hold_cnt_r == HOLD_LAST);
  assign miss_s   = (estado_r == JOGO) && conta_nivel && (to_cnt_r == TO_LAST);

  // state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_r <= OCIOSO;
    end else begin
      estado_r <= estado_s;
    end
  end

  // next-state logic; reset_nivel overrides every state
  always_comb begin
    estado_s = estado_r;
    if (reset_nivel) begin
      estado_s = OCIOSO;
    end else begin
      case (estado_r)
        OCIOSO:  estado_s = PREP;
        PREP:    estado_s = (prep_cnt_r == PREP_LAST) ? ESPERA : PREP;
        ESPERA:  estado_s = gerar_nova_jogada ? JOGO : ESPERA;
        JOGO:    estado_s = (hit_s || miss_s) ? PONTO : JOGO;
        PONTO:   estado_s = PREP;
        default: estado_s = OCIOSO;
      endcase
    end
  end

  // counters, target latch, result and score
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prep_cnt_r <= '0;
      hold_cnt_r <= '0;
      to_cnt_r   <= '0;
      tol_r      <= 8'd0;
      alvo_r     <= 8'h80;
      pontos_r   <= 8'd0;
      acerto_r   <= 1'b0;
    end else if (reset_nivel) begin
      prep_cnt_r <= '0;
      hold_cnt_r <= '0;
      to_cnt_r   <= '0;
      pontos_r   <= 8'd0;
    end else begin
      prep_cnt_r <= (estado_r == PREP) ? (prep_cnt_r + PREP_ONE) : '0;
      if ((estado_r == ESPERA) && gerar_nova_jogada) begin
        alvo_r     <= clamp_alvo(lfsr_q, 8'(ALVO_MIN), 8'(ALVO_MAX));
        tol_r      <= 8'(TOL) >> nivel;
        hold_cnt_r <= '0;
        to_cnt_r   <= '0;
      end else if ((estado_r == JOGO) && conta_nivel) begin
        hold_cnt_r <= dentro_s ? (hold_cnt_r + HOLD_ONE) : '0;
        to_cnt_r   <= to_cnt_r + TO_ONE;
      end
      // result is captured on entry to PONTO so it is valid with the pulse
      if (hit_s || miss_s) begin
        acerto_r <= hit_s;
        if (hit_s && (pontos_r != 8'hFF)) begin
          pontos_r <= pontos_r + 8'd1;
        end
      end
    end
  end

  assign prep_done    = (estado_r == ESPERA);
  assign ponto_evento = (estado_r == PONTO);
  assign db_estado    = estado_r;
  assign acerto       = acerto_r;
  assign alvo         = alvo_r;
  assign pontos       = pontos_r;

endmodule

// File: doc/rodada_juiz.md
# rodada_juiz

Round judge and preparation responder for the game control FSM. It answers the controller's handshake: it produces `prep_done` after a fixed preparation delay, latches a pseudo-random balance target when `gerar_nova_jogada` pulses, and times the player's balance attempt while `conta_nivel` is high. It then ends the round with a one-cycle `ponto_evento`, reporting whether the round was a hit or a miss and keeping the score. It sits beside the controller in the top level and drives its `prep_done` and `ponto_evento` inputs.

## Interface
Parameters:
- `PREP_CYCLES`, 50_000_000: length of the preparation delay, in clock cycles.
- `HOLD_CYCLES`, 100_000_000: number of consecutive in-tolerance cycles required for a hit.
- `TIMEOUT_CYCLES`, 500_000_000: number of counted cycles after which the round is a miss.
- `TOL`, 16: base angle tolerance at level 0.
- `ALVO_MIN`, 32: lower clamp for the target.
- `ALVO_MAX`, 223: upper clamp for the target.

Ports:
- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `reset_nivel`  in  1  from controller; high means idle (calibration or level select).
- `gerar_nova_jogada`  in  1  from controller; one-cycle request to generate a new target.
- `conta_nivel`  in  1  from controller; high while the round is live.
- `nivel`  in  2  difficulty level, sampled on `gerar_nova_jogada`.
- `angulo`  in  8  current platform angle, unsigned, 128 means level.
- `prep_done`  out  1  level; preparation finished, waiting for a request.
- `ponto_evento`  out  1  one-cycle pulse marking the end of a round.
- `acerto`  out  1  result of the last round: 1 = hit, 0 = miss.
- `alvo`  out  8  current target angle.
- `pontos`  out  8  score, saturating.
- `db_estado`  out  3  current state, for debug.

## Operation
States and encodings: OCIOSO=0, PREP=1, ESPERA=2, JOGO=3, PONTO=4.
- `reset_nivel`=1 in any state: go to OCIOSO at the next edge. Counters and `pontos` clear. No `ponto_evento` is issued.
- OCIOSO: when `reset_nivel`=0, go to PREP.
- PREP: the prep counter runs 0..PREP_CYCLES-1. At the last count, go to ESPERA.
- ESPERA: `prep_done`=1. When `gerar_nova_jogada`=1:
  - latch `alvo` = clamp(lfsr, ALVO_MIN, ALVO_MAX);
  - latch tolerance `tol` = TOL >> `nivel`;
  - clear both counters;
  - go to JOGO.
- JOGO: the counters advance only while `conta_nivel`=1; when it is 0 they hold.
  - `dentro` = |`angulo` − `alvo`| ≤ `tol`. Compute the difference in 9-bit arithmetic, then take the magnitude.
  - Hold counter: +1 while `dentro`, clears to 0 when not `dentro`.
  - Timeout counter: +1 on every counted cycle.
  - Hit: `dentro` and hold counter = HOLD_CYCLES-1.
  - Miss: timeout counter = TIMEOUT_CYCLES-1.
  - Hit and miss in the same cycle resolve as a hit.
  - On hit or miss: go to PONTO.
- PONTO: `ponto_evento`=1 for exactly this cycle. Set `acerto` to the result. On a hit, `pontos` += 1, saturating at 255. Go to PREP unconditionally.
- `gerar_nova_jogada` outside ESPERA is ignored.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, seed 0x01. It free-runs every cycle from reset and never reaches 0.

## Timing
- Reset values: `prep_done`=0, `ponto_evento`=0, `acerto`=0, `alvo`=0x80, `pontos`=0, `db_estado`=0 (OCIOSO).
- All outputs are registered or decoded from the state register only. There are no combinational paths from inputs to outputs.
- `reset_nivel` falls at edge k: PREP from edge k+1; `prep_done` high from edge k+1+PREP_CYCLES.
- `gerar_nova_jogada` high during cycle k (in ESPERA): `prep_done` low and `alvo` valid from edge k+1.
- Hit or miss detected in cycle k: `ponto_evento` high in cycle k+1, PREP in cycle k+2.
- The controller leaves its play state on the edge that ends the `ponto_evento` cycle. The pulse must therefore be exactly one cycle.
- Asynchronous `reset` mid-round returns everything to the reset values, including the LFSR seed.

## Structure
- Package `rodada_pkg` holds:
  - the state encodings;
  - the LFSR width, taps and seed;
  - the clamp defaults.
- Sub-module `rodada_lfsr`: 8-bit free-running LFSR with output `q[7:0]`.
- Counter widths are $clog2 of their parameters.

## Test plan
Parameters for all scenarios: PREP_CYCLES=4, HOLD_CYCLES=8, TIMEOUT_CYCLES=50, TOL=8, unless stated.
- Reset released, `reset_nivel` 1→0 at edge 0 → `prep_done`=1 from edge 5; `db_estado` sequence 0,1,1,1,1,2.
- `gerar_nova_jogada` pulse with `nivel`=0, then `conta_nivel`=1 and `angulo`=`alvo`+8 held → `ponto_evento` after 8 counted cycles plus 1; `acerto`=1; `pontos`=1.
- Same as above with `nivel`=1 and `angulo`=`alvo`+8 (outside tolerance 4) → miss after 50 counted cycles; `acerto`=0; `pontos` unchanged.
- `angulo` in tolerance for 7 cycles, out for 1, in for 8 → hit only at the end of the second run. `conta_nivel` dropped for 10 cycles mid-round → counters frozen, timing shifted by 10.
- HOLD_CYCLES=TIMEOUT_CYCLES=8 with `angulo` held in tolerance → hit wins. 256 forced hits → `pontos` saturates at 255.
- `reset_nivel`=1 during JOGO → OCIOSO next cycle, no `ponto_evento`, `pontos`=0. LFSR values 0x00–0x1F and 0xE0–0xFF → `alvo` = 32 and 223 respectively.
